uart_tx_feeder: RTL and testbench

- Buffered transmit front end that sits directly upstream of the UART transmitter.
- Accepts bytes from the host side into a 2^FIFO_W-deep FIFO.
- Drains the FIFO into the transmitter using its tx_start / din / tx_done_tick handshake, one frame at a time.
- Host can burst-write without waiting on the baud rate; the block reports full/empty/count/overflow status.

---
 rtl/uart_tx_feeder_pkg.sv | 12 +
 rtl/uart_tx_feeder_fifo_sync.sv | 52 +++++
 rtl/uart_tx_feeder.sv | 128 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding and default widths.
package uart_tx_feeder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int UART_DBIT   = 8;
  localparam int UART_FIFO_W = 4;

endpackage

// File: rtl/uart_tx_feeder_fifo_sync.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata whenever empty is low.
module fifo_sync #(
  parameter int D_BIT  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [D_BIT-1:0]  wdata,
  output logic [D_BIT-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [D_BIT-1:0]  mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Full/empty gate the requests using the pre-edge occupancy, so a full FIFO never writes through.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign full  = (count == DEPTH[ADDR_W:0]);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered UART transmit front end: FIFO plus a two-state drain FSM.
// Optional watchdog on stuck frames enabled by defining UART_TX_FEEDER_TIMEOUT_EN.
import uart_tx_feeder_pkg::*;

module uart_tx_feeder #(
  parameter int D_BIT     = UART_DBIT,
  parameter int FIFO_W    = UART_FIFO_W,
  parameter int TO_CYCLES = 32768,
  parameter int TO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [D_BIT-1:0]  wr_data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [D_BIT-1:0]  tx_din,
  output logic              full,
  output logic              empty,
  output logic [FIFO_W:0]   count,
  output logic              busy,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_timeout
);

  state_t           state, state_nxt;
  logic             pop;
  logic [D_BIT-1:0] head;
  logic [D_BIT-1:0] din_nxt;
  logic             start_nxt;
  logic             busy_nxt;

  fifo_sync #(
    .D_BIT  (D_BIT),
    .ADDR_W (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_en),
    .rd    (pop),
    .wdata (wr_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            to_flag, to_flag_nxt;
  assign tx_timeout = to_flag;
`else
  assign tx_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    start_nxt = 1'b0;
    din_nxt   = tx_din;
    pop       = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    to_flag_nxt = to_flag;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          din_nxt   = head;
          start_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ST_BUSY;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
          to_cnt_nxt = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (tx_done_tick) begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // Abandon the frame after TO_CYCLES busy cycles; the popped byte is lost.
        end else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
          busy_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
          to_flag_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      to_cnt   <= '0;
      to_flag  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tx_start <= start_nxt;
      tx_din   <= din_nxt;
      busy     <= busy_nxt;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      to_cnt   <= to_cnt_nxt;
      to_flag  <= to_flag_nxt;
`endif
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset)              overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
    else if (ovf_clr)        overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (default build, FIFO_W=4).
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow;
  logic       ovf_clr;
  logic       tx_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .tx_timeout   (tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_din"},   tx_din,   0);
    check({tag, "_full"},     full,     0);
    check({tag, "_empty"},    empty,    1);
    check({tag, "_count"},    count,    0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_timeout"},  tx_timeout, 0);
  endtask

  // Pulse tx_done_tick across exactly one edge.
  task automatic done_pulse();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  initial begin
    int wait_n;
    int peak;
    logic [7:0] exp_din;

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; tx_done_tick = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_reset_state("rst");

    // Done tick while idle must be ignored.
    done_pulse();
    check("idle_done_busy",  busy, 0);
    check("idle_done_start", tx_start, 0);

    // Single write: tx_start appears after the second edge.
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_cnt1",   count, 1);
    check("single_nostart", tx_start, 0);
    tick();
    check("single_start", tx_start, 1);
    check("single_din",   tx_din, 8'hA5);
    check("single_busy",  busy, 1);
    check("single_empty", empty, 1);
    tick();
    check("single_start_off", tx_start, 0);
    tick(); tick();
    check("single_din_hold", tx_din, 8'hA5);
    check("single_busy_hold", busy, 1);
    done_pulse();
    check("single_idle_busy",  busy, 0);
    check("single_idle_empty", empty, 1);

    // Burst of three writes, 20-cycle frames.
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (i == 1) begin
        check("burst0_start", tx_start, 1);
        check("burst0_din",   tx_din, 8'h01);
      end
    end
    wr_en = 1'b0;
    check("burst_peak", peak, 2);
    repeat (18) tick();
    check("burst0_hold", tx_din, 8'h01);
    done_pulse();
    for (int f = 1; f < 3; f++) begin
      wait_n = 0;
      while (tx_start !== 1'b1 && wait_n < 50) begin
        tick();
        wait_n++;
      end
      check($sformatf("burst%0d_gap", f), wait_n, 1);
      check($sformatf("burst%0d_din", f), tx_din, 8'(f + 1));
      repeat (19) tick();
      check($sformatf("burst%0d_hold", f), tx_din, 8'(f + 1));
      done_pulse();
    end
    tick();
    check("burst_end_empty", empty, 1);
    check("burst_end_busy",  busy, 0);

    // Fill: 17 writes with no done ticks, first word goes in flight.
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    check("fill_full",  full, 1);
    check("fill_count", count, 16);
    check("fill_din",   tx_din, 8'h10);
    check("fill_ovf0",  overflow, 0);
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("drop_ovf",   overflow, 1);
    check("drop_count", count, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("setwins_ovf", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr2_ovf", overflow, 0);

    // Write on full coinciding with a pop: dropped, count 15.
    done_pulse();
    check("pre_pop_count", count, 16);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("coinc_ovf",   overflow, 1);
    check("coinc_count", count, 15);
    check("coinc_start", tx_start, 1);
    check("coinc_din",   tx_din, 8'h11);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Drain down to 5 words, checking FIFO order.
    exp_din = 8'h11;
    for (int k = 0; k < 20 && count != 5'd5; k++) begin
      done_pulse();
      tick();
      exp_din++;
    end
    check("drain_count", count, 5);
    check("drain_din",   tx_din, exp_din);
    check("drain_last",  exp_din, 8'h1B);
    check("drain_busy",  busy, 1);

    // Reset mid-frame.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("midrst");
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tick();
    check("restart_start", tx_start, 1);
    check("restart_din",   tx_din, 8'h5A);
    check("restart_count", count, 0);
    done_pulse();
    check("restart_idle", busy, 0);
    check("final_timeout", tx_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
